id_ex_pipe_reg_p: RTL and testbench
===================================

Name: id_ex_pipe_reg_p

Overview:
Parametrised ID/EX pipeline register, the next generation of the fixed-width ID/EX stage latch. It carries a generic control bundle, N data operands and three register IDs from decode to execute. It adds a valid bit, a stall (hold) input, two independent flush sources with a selectable clear mode, and a saturating bubble counter for performance monitoring. It sits between the decode stage and the EX stage and is driven by the hazard unit.

Parameters:
CTRL_W, 8, width of control bundle (WB/MEM/EX control bits packed)
DATA_W, 32, width of each data operand
NUM_DATA, 3, number of data operands (e.g. rs data, rt data, sign-extended immediate)
REG_W, 5, width of each register ID (rs, rt, rd packed, 3 fields)
CLEAR_ALL_ON_FLUSH, 0, 0: flush clears control/valid only; 1: flush also zeros data and register IDs
CNT_W, 16, width of bubble counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
stall  input  1  hold all stage contents this cycle
flush_lwstall  input  1  insert bubble (load-use hazard)
flush_branch  input  1  insert bubble (branch/jump squash)
valid_in  input  1  decode-stage instruction valid
ctrl_in  input  CTRL_W  control bundle from decode
data_in  input  NUM_DATA*DATA_W  operands, operand k at bits [k*DATA_W +: DATA_W]
regid_in  input  3*REG_W  {rd, rt, rs}, rs in LSBs
bubble_clr  input  1  synchronous clear of bubble counter
valid_out  output  1  EX-stage instruction valid
ctrl_out  output  CTRL_W  registered control bundle
data_out  output  NUM_DATA*DATA_W  registered operands
regid_out  output  3*REG_W  registered register IDs
bubble_count  output  CNT_W  number of flush events, saturating

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-stall/flush): valid_out=0, ctrl_out=0, data_out=0, regid_out=0, bubble_count=0. Outputs stay at 0 while reset=0. The first rising edge after release applies the normal rules.
- Latency: 1 cycle from inputs to outputs. All outputs are registered, with no combinational path from input to output.
- Per rising edge, the priority is flush > stall > load, where flush = flush_lwstall | flush_branch:
  - Flush: valid_out<=0, ctrl_out<=0. With CLEAR_ALL_ON_FLUSH=0, data_out and regid_out hold their previous values (they are not loaded). With CLEAR_ALL_ON_FLUSH=1, they are loaded with 0.
  - Stall (no flush): every output holds, including valid_out.
  - Load: valid_out<=valid_in. ctrl_out<=valid_in ? ctrl_in : 0. data_out<=data_in and regid_out<=regid_in regardless of valid_in.
- Flush together with stall: flush wins. A bubble is inserted and the previous instruction is discarded.
- Both flush sources asserted together: treated as a single flush event.
- bubble_count:
  - +1 on each edge where flush=1. A simultaneous dual-source flush counts as 1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - bubble_clr=1: count<=0 on that edge. Clear wins over a simultaneous increment.
  - The counter updates even while stall=1. Loads with valid_in=0 are not counted.
- ctrl_out is 0 whenever valid_out=0. This invariant holds in all cases.
- Widths: no truncation or extension. Every field maps bit-for-bit.

Test Plan:
- Reset mid-stream: load ctrl_in=8'hA5, data all 32'h1234_5678, valid_in=1, then pull reset low between clock edges -> all outputs 0 immediately without a clock edge. bubble_count=0.
- Normal load: valid_in=1, ctrl_in=8'h3C, data_in={32'h3,32'h2,32'h1}, regid_in={5'd9,5'd8,5'd7} -> next edge valid_out=1, ctrl_out=8'h3C, data_out/regid_out equal inputs.
- Stall hold: after the previous load, stall=1 for 3 cycles with changing inputs -> outputs unchanged for all 3 cycles. Release stall -> new inputs appear after 1 edge.
- Flush modes: flush_lwstall=1 with CLEAR_ALL_ON_FLUSH=0 -> valid_out=0, ctrl_out=0, data_out=32'h1/2/3 retained. Repeat with CLEAR_ALL_ON_FLUSH=1 -> data_out=0, regid_out=0.
- Flush beats stall, dual source: stall=1, flush_lwstall=1, flush_branch=1 on one edge -> valid_out=0, ctrl_out=0, bubble_count increments by exactly 1.
- Counter boundaries: CNT_W=4, 17 consecutive flushes -> bubble_count saturates at 4'hF. Then bubble_clr=1 together with flush=1 -> bubble_count=0. valid_in=0 loads leave the count unchanged and give ctrl_out=0.

Source files
------------

// File: rtl/id_ex_pipe_reg_p.sv
// ID/EX pipeline register: carries control, operands and register IDs from decode to execute,
// with stall hold, dual-source flush (selectable clear depth) and a saturating bubble counter.
module id_ex_pipe_reg_p #(
    parameter int CTRL_W             = 8,
    parameter int DATA_W             = 32,
    parameter int NUM_DATA           = 3,
    parameter int REG_W              = 5,
    parameter int CLEAR_ALL_ON_FLUSH = 0,
    parameter int CNT_W              = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush_lwstall,
    input  logic                       flush_branch,
    input  logic                       valid_in,
    input  logic [CTRL_W-1:0]          ctrl_in,
    input  logic [NUM_DATA*DATA_W-1:0] data_in,
    input  logic [3*REG_W-1:0]         regid_in,
    input  logic                       bubble_clr,
    output logic                       valid_out,
    output logic [CTRL_W-1:0]          ctrl_out,
    output logic [NUM_DATA*DATA_W-1:0] data_out,
    output logic [3*REG_W-1:0]         regid_out,
    output logic [CNT_W-1:0]           bubble_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                       flush;
    logic                       vld_p1;
    logic [CTRL_W-1:0]          ctrl_p1;
    logic [NUM_DATA*DATA_W-1:0] data_p1;
    logic [3*REG_W-1:0]         regid_p1;
    logic [CNT_W-1:0]           bubble_cnt_p1;

    // Both hazard sources collapse into one bubble event.
    assign flush = flush_lwstall | flush_branch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_ONE;
    endfunction

    // ID -> EX stage boundary: control/valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
        end else if (!stall) begin
            vld_p1  <= valid_in;
            ctrl_p1 <= valid_in ? ctrl_in : '0;
        end
    end

    // ID -> EX stage boundary: operands and register IDs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_p1  <= '0;
            regid_p1 <= '0;
        end else if (flush) begin
            if (CLEAR_ALL_ON_FLUSH != 0) begin
                data_p1  <= '0;
                regid_p1 <= '0;
            end
        end else if (!stall) begin
            data_p1  <= data_in;
            regid_p1 <= regid_in;
        end
    end

    // Counter keeps running under stall; clear takes priority over a same-edge bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt_p1 <= '0;
        end else if (bubble_clr) begin
            bubble_cnt_p1 <= '0;
        end else if (flush) begin
            bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
        end
    end

    assign valid_out    = vld_p1;
    assign ctrl_out     = ctrl_p1;
    assign data_out     = data_p1;
    assign regid_out    = regid_p1;
    assign bubble_count = bubble_cnt_p1;

endmodule

// File: tb/tb_id_ex_pipe_reg_p.sv
// Bench for id_ex_pipe_reg_p: two instances (hold-data flush with 4-bit counter, clear-all flush
// with 16-bit counter) driven in lockstep and checked against a queued reference model.
module tb_id_ex_pipe_reg_p;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush_lwstall, flush_branch, valid_in, bubble_clr;
    logic [7:0]  ctrl_in;
    logic [95:0] data_in;
    logic [14:0] regid_in;

    logic        valid_a, valid_b;
    logic [7:0]  ctrl_a, ctrl_b;
    logic [95:0] data_a, data_b;
    logic [14:0] regid_a, regid_b;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        vld;
        logic [7:0]  ctrl;
        logic [95:0] data_a;
        logic [14:0] regid_a;
        logic [95:0] data_b;
        logic [14:0] regid_b;
        logic [3:0]  cnt_a;
        logic [15:0] cnt_b;
    } exp_t;

    exp_t q[$];

    logic        m_vld;
    logic [7:0]  m_ctrl;
    logic [95:0] m_data_a, m_data_b;
    logic [14:0] m_regid_a, m_regid_b;
    int          m_cnt_a, m_cnt_b;

    id_ex_pipe_reg_p #(.CLEAR_ALL_ON_FLUSH(0), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .flush_lwstall(flush_lwstall),
        .flush_branch(flush_branch), .valid_in(valid_in), .ctrl_in(ctrl_in),
        .data_in(data_in), .regid_in(regid_in), .bubble_clr(bubble_clr),
        .valid_out(valid_a), .ctrl_out(ctrl_a), .data_out(data_a),
        .regid_out(regid_a), .bubble_count(cnt_a)
    );

    id_ex_pipe_reg_p #(.CLEAR_ALL_ON_FLUSH(1), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .flush_lwstall(flush_lwstall),
        .flush_branch(flush_branch), .valid_in(valid_in), .ctrl_in(ctrl_in),
        .data_in(data_in), .regid_in(regid_in), .bubble_clr(bubble_clr),
        .valid_out(valid_b), .ctrl_out(ctrl_b), .data_out(data_b),
        .regid_out(regid_b), .bubble_count(cnt_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input string field,
                       input logic [95:0] obs, input logic [95:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed %0h expected %0h", tag, field, obs, expv);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk(e.tag, "valid_a", 96'(valid_a), 96'(e.vld));
        chk(e.tag, "valid_b", 96'(valid_b), 96'(e.vld));
        chk(e.tag, "ctrl_a",  96'(ctrl_a),  96'(e.ctrl));
        chk(e.tag, "ctrl_b",  96'(ctrl_b),  96'(e.ctrl));
        chk(e.tag, "data_a",  data_a,       e.data_a);
        chk(e.tag, "data_b",  data_b,       e.data_b);
        chk(e.tag, "regid_a", 96'(regid_a), 96'(e.regid_a));
        chk(e.tag, "regid_b", 96'(regid_b), 96'(e.regid_b));
        chk(e.tag, "cnt_a",   96'(cnt_a),   96'(e.cnt_a));
        chk(e.tag, "cnt_b",   96'(cnt_b),   96'(e.cnt_b));
    endtask

    task automatic model_reset();
        m_vld = 1'b0; m_ctrl = '0;
        m_data_a = '0; m_data_b = '0; m_regid_a = '0; m_regid_b = '0;
        m_cnt_a = 0; m_cnt_b = 0;
        q.delete();
    endtask

    function automatic exp_t zero_exp(input string tag);
        exp_t e;
        e.tag = tag; e.vld = 1'b0; e.ctrl = '0;
        e.data_a = '0; e.regid_a = '0; e.data_b = '0; e.regid_b = '0;
        e.cnt_a = '0; e.cnt_b = '0;
        return e;
    endfunction

    // Drive one cycle of stimulus, push the expected post-edge state, then check after the edge.
    task automatic step(input string tag, input logic stl, input logic fl, input logic fb,
                        input logic vin, input logic [7:0] c, input logic [95:0] d,
                        input logic [14:0] r, input logic clr);
        exp_t e;
        bit   bubble;
        stall = stl; flush_lwstall = fl; flush_branch = fb;
        valid_in = vin; ctrl_in = c; data_in = d; regid_in = r; bubble_clr = clr;

        bubble = fl || fb;
        if (bubble) begin
            m_vld = 1'b0; m_ctrl = '0; m_data_b = '0; m_regid_b = '0;
        end else if (!stl) begin
            m_vld = vin;
            m_ctrl = vin ? c : 8'h00;
            m_data_a = d; m_data_b = d; m_regid_a = r; m_regid_b = r;
        end
        if (clr) begin
            m_cnt_a = 0; m_cnt_b = 0;
        end else if (bubble) begin
            if (m_cnt_a < 15) m_cnt_a++;
            if (m_cnt_b < 65535) m_cnt_b++;
        end
        e.tag = tag; e.vld = m_vld; e.ctrl = m_ctrl;
        e.data_a = m_data_a; e.regid_a = m_regid_a;
        e.data_b = m_data_b; e.regid_b = m_regid_b;
        e.cnt_a = 4'(m_cnt_a); e.cnt_b = 16'(m_cnt_b);
        q.push_back(e);

        @(posedge clk);
        #1;
        checks++;
        assert (q.size() > 0) else begin
            errors++;
            $error("FAIL %s scoreboard observed empty expected entry", tag);
        end
        if (q.size() > 0) chk_all(q.pop_front());
    endtask

    initial begin
        reset = 1'b0; stall = 0; flush_lwstall = 0; flush_branch = 0;
        valid_in = 0; ctrl_in = '0; data_in = '0; regid_in = '0; bubble_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all(zero_exp("rst_init"));
        reset = 1'b1;

        step("ld_a5",  0, 0, 0, 1, 8'hA5, {3{32'h1234_5678}}, {5'd3, 5'd2, 5'd1}, 0);
        step("fl_pre", 0, 0, 1, 1, 8'hA5, {3{32'h1234_5678}}, {5'd3, 5'd2, 5'd1}, 0);
        step("ld_a5b", 0, 0, 0, 1, 8'hA5, {3{32'h1234_5678}}, {5'd3, 5'd2, 5'd1}, 0);

        // Asynchronous reset between edges, then held across an edge.
        #3 reset = 1'b0;
        #1;
        model_reset();
        chk_all(zero_exp("rst_async"));
        @(posedge clk);
        #1;
        chk_all(zero_exp("rst_hold"));
        reset = 1'b1;

        step("ld_3c",  0, 0, 0, 1, 8'h3C, {32'h3, 32'h2, 32'h1}, {5'd9, 5'd8, 5'd7}, 0);
        for (int i = 0; i < 3; i++)
            step("stall", 1, 0, 0, 1, 8'(8'h10 + i), {3{32'(i + 100)}}, 15'(i + 20), 0);
        step("unstall", 0, 0, 0, 1, 8'h5A, {32'h6, 32'h5, 32'h4}, {5'd12, 5'd11, 5'd10}, 0);
        step("ld_3c2", 0, 0, 0, 1, 8'h3C, {32'h3, 32'h2, 32'h1}, {5'd9, 5'd8, 5'd7}, 0);
        step("fl_lw",  0, 1, 0, 1, 8'hFF, {3{32'hDEAD_BEEF}}, 15'h7FFF, 0);
        step("ld_77",  0, 0, 0, 1, 8'h77, {32'hC, 32'hB, 32'hA}, {5'd31, 5'd0, 5'd16}, 0);
        step("fl_dual_stall", 1, 1, 1, 1, 8'h11, {3{32'hFFFF_FFFF}}, 15'h1234, 0);

        for (int i = 0; i < 17; i++)
            step("fl_sat", 0, (i % 2) == 0, (i % 3) == 0 || (i % 2) != 0, 1, 8'h22,
                 {3{32'(i)}}, 15'(i), 0);
        step("clr_fl", 0, 1, 0, 1, 8'h33, {3{32'h55}}, 15'h55, 1);
        step("ld_inv", 0, 0, 0, 0, 8'hEE, {32'h9, 32'h8, 32'h7}, {5'd4, 5'd5, 5'd6}, 0);
        step("fl_br",  0, 0, 1, 0, 8'hEE, {3{32'h1}}, 15'h1, 0);
        step("clr",    0, 0, 0, 1, 8'h44, {3{32'h2}}, 15'h2, 1);
        step("ld_inv2", 0, 0, 0, 0, 8'h99, {3{32'h3}}, 15'h3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
